// File: rtl/cpu_rp2a03_apu_pulse_timer_sequencer.sv
// Pulse channel core: 11-bit period register shared with the sweep unit, period
// down-counter, 8-step duty sequencer, length counter and registered gate bit.
module cpu_rp2a03_apu_pulse_timer_sequencer #(
  parameter int LENGTH_LOAD_WINS = 1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        apu_cycle_i,
  input  logic        half_frame_i,
  input  logic [7:0]  channel_regs_wr_data_i,
  input  logic        duty_reg_wr_i,
  input  logic        timer_low_reg_wr_i,
  input  logic        timer_high_reg_wr_i,
  input  logic        channel_enable_i,
  input  logic [10:0] target_timer_value_i,
  input  logic        timer_value_update_i,
  input  logic        muting_is_inactive_i,
  output logic [10:0] timer_value_o,
  output logic        length_active_o,
  output logic        pulse_gate_o
);

  // All inputs are single-cycle strobes or levels; there is no handshake, and
  // every strobe seen on a rising clk edge is acted on in that edge.

  logic [10:0] period;
  logic [10:0] timer_cnt;
  logic [2:0]  step;
  logic [1:0]  duty;
  logic        halt;
  logic [7:0]  length;
  logic        pulse_gate;

  logic        timer_expired;
  logic [7:0]  length_load_value;
  logic [7:0]  length_next;
  logic        length_dec;
  logic        duty_bit;

  function automatic logic [7:0] length_table(input logic [4:0] idx);
    logic [7:0] v;
    case (idx)
      5'd0:  v = 8'd10;   5'd1:  v = 8'd254;  5'd2:  v = 8'd20;   5'd3:  v = 8'd2;
      5'd4:  v = 8'd40;   5'd5:  v = 8'd4;    5'd6:  v = 8'd80;   5'd7:  v = 8'd6;
      5'd8:  v = 8'd160;  5'd9:  v = 8'd8;    5'd10: v = 8'd60;   5'd11: v = 8'd10;
      5'd12: v = 8'd14;   5'd13: v = 8'd12;   5'd14: v = 8'd26;   5'd15: v = 8'd14;
      5'd16: v = 8'd12;   5'd17: v = 8'd16;   5'd18: v = 8'd24;   5'd19: v = 8'd18;
      5'd20: v = 8'd48;   5'd21: v = 8'd20;   5'd22: v = 8'd96;   5'd23: v = 8'd22;
      5'd24: v = 8'd192;  5'd25: v = 8'd24;   5'd26: v = 8'd72;   5'd27: v = 8'd26;
      5'd28: v = 8'd16;   5'd29: v = 8'd28;   5'd30: v = 8'd32;   default: v = 8'd30;
    endcase
    return v;
  endfunction

  // Each pattern is indexed by step; bit n is the waveform level at step n.
  function automatic logic duty_table(input logic [1:0] d, input logic [2:0] s);
    logic [7:0] pattern;
    case (d)
      2'd0:    pattern = 8'b0000_0010;
      2'd1:    pattern = 8'b0000_0110;
      2'd2:    pattern = 8'b0001_1110;
      default: pattern = 8'b1111_1001;
    endcase
    return pattern[s];
  endfunction

  assign timer_expired     = (timer_cnt == 11'd0);
  assign length_load_value = length_table(channel_regs_wr_data_i[7:3]);
  assign length_dec        = half_frame_i && !halt && (length != 8'd0);
  assign duty_bit          = duty_table(duty, step);

  always_comb begin
    length_next = length;
    if (!channel_enable_i) begin
      length_next = 8'd0;
    end else if (timer_high_reg_wr_i) begin
      // Table entries are all >= 2, so the non-winning variant cannot wrap.
      if (half_frame_i && !halt && (LENGTH_LOAD_WINS == 0)) begin
        length_next = length_load_value - 8'd1;
      end else begin
        length_next = length_load_value;
      end
    end else if (length_dec) begin
      length_next = length - 8'd1;
    end
  end

  // Register writes own the period for the cycle; the sweep update is dropped.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      period <= 11'd0;
    end else if (timer_low_reg_wr_i || timer_high_reg_wr_i) begin
      if (timer_low_reg_wr_i) begin
        period[7:0] <= channel_regs_wr_data_i;
      end
      if (timer_high_reg_wr_i) begin
        period[10:8] <= channel_regs_wr_data_i[2:0];
      end
    end else if (timer_value_update_i) begin
      period <= target_timer_value_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      timer_cnt <= 11'd0;
    end else if (apu_cycle_i) begin
      if (timer_expired) begin
        timer_cnt <= period;
      end else begin
        timer_cnt <= timer_cnt - 11'd1;
      end
    end
  end

  // Sequencer counts down; a timer-high write restarts it from step 0.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      step <= 3'd0;
    end else if (timer_high_reg_wr_i) begin
      step <= 3'd0;
    end else if (apu_cycle_i && timer_expired) begin
      step <= step - 3'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      duty <= 2'd0;
      halt <= 1'b0;
    end else if (duty_reg_wr_i) begin
      duty <= channel_regs_wr_data_i[7:6];
      halt <= channel_regs_wr_data_i[5];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      length <= 8'd0;
    end else begin
      length <= length_next;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pulse_gate <= 1'b0;
    end else begin
      pulse_gate <= duty_bit && (length != 8'd0) && muting_is_inactive_i;
    end
  end

  assign timer_value_o   = period;
  assign length_active_o = (length != 8'd0);
  assign pulse_gate_o    = pulse_gate;

endmodule

// File: doc/cpu_rp2a03_apu_pulse_timer_sequencer.md
Name: cpu_RP2A03_apu_pulse_timer_sequencer

Overview:
Downstream consumer and upstream feeder of the pulse-channel sweep unit. Holds the channel's 11-bit timer period, exported as timer_value_o; accepts sweep period updates; runs the period down-counter and the 8-step duty sequencer. Also owns the length counter and produces the registered, gated pulse waveform bit that the envelope/volume stage consumes.

Parameters:
LENGTH_LOAD_WINS, 1, when 1 a length load and a half-frame decrement in the same cycle yield the loaded value; when 0 they yield loaded value minus 1

Ports:
clk_i  input  1  clock (CPU clock)
rst_n_i  input  1  asynchronous active-low reset
apu_cycle_i  input  1  strobe, one clk every other CPU cycle; clocks timer
half_frame_i  input  1  frame-counter half-frame strobe; clocks length counter
channel_regs_wr_data_i  input  8  register write data
duty_reg_wr_i  input  1  $4000/$4004 write: duty [7:6], length halt [5]
timer_low_reg_wr_i  input  1  $4002/$4006 write: period[7:0]
timer_high_reg_wr_i  input  1  $4003/$4007 write: length index [7:3], period[10:8]
channel_enable_i  input  1  $4015 enable bit for this channel (level)
target_timer_value_i  input  11  new period from sweep unit
timer_value_update_i  input  1  sweep strobe: load target into period
muting_is_inactive_i  input  1  sweep mute flag (1 = not muted)
timer_value_o  output  11  current period register, to sweep unit
length_active_o  output  1  length counter non-zero ($4015 status)
pulse_gate_o  output  1  gated waveform bit, registered

Behaviour:
- Reset (async, rst_n_i low): period 0, timer counter 0, step 0, duty 0, halt 0, length 0; all outputs 0. Reset mid-operation clears immediately, regardless of clock.
- Period register (11 bit): timer_low write sets [7:0]; timer_high write sets [10:8]. Other bits are held.
- Period priority: if any timer write coincides with timer_value_update_i, the register write wins and the sweep update is dropped that cycle. Otherwise timer_value_update_i loads target_timer_value_i. Effect is visible on timer_value_o the next clk.
- Timer counter (11 bit), acts only on apu_cycle_i:
  - If counter == 0: reload with period and advance the sequencer.
  - Otherwise: decrement.
  - Register writes do not touch the counter.
  - Output frequency = apu rate / (period+1) / 8.
- Sequencer step (3 bit):
  - Advance = decrement mod 8 (0→7→6…→1→0).
  - A timer_high write forces step 0. This takes priority over a simultaneous advance.
- Duty tables, bit for step 0..7 listed left to right:
  - duty0 = 0 1 0 0 0 0 0 0
  - duty1 = 0 1 1 0 0 0 0 0
  - duty2 = 0 1 1 1 1 0 0 0
  - duty3 = 1 0 0 1 1 1 1 1
  - A duty write takes effect on the next clk without resetting the step.
- Length counter (8 bit):
  - Load value = table[index], index 0..31: 10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30.
  - Load occurs on timer_high write only while channel_enable_i = 1.
  - Decrement occurs on half_frame_i when halt = 0 and counter != 0. The counter never wraps below 0.
  - channel_enable_i = 0 forces the counter to 0 every cycle and blocks loads.
  - Load plus decrement in the same cycle resolves per LENGTH_LOAD_WINS.
- length_active_o = (length != 0), combinational from the register.
- pulse_gate_o is registered each clk as duty_bit(duty, step) AND length != 0 AND muting_is_inactive_i. It therefore lags its inputs by 1 clk.
- No state machine beyond the counters. All strobes are single-cycle; consecutive strobes are each honoured.

Test Plan:
- Reset, then write $4002=0x08, $4003=0x08 (index 1, period 0x008), enable=1 → timer_value_o=0x008 next clk, length=254, step=0.
- Set duty=2, strobe apu_cycle_i continuously → step advances every 9 apu cycles; pulse_gate_o repeats over 72 apu cycles: high for 36, low for 36. Verify the 0,7,6,…,1 step order against table bits.
- Set period 0x100, pulse timer_value_update_i with target 0x180 → timer_value_o=0x180. Then assert update together with a $4002 write of 0x55 → result 0x155, sweep update ignored.
- Load index 3 (length 2), halt=0, issue 3 half_frame_i pulses → length 1, 0, 0; length_active_o falls after the second pulse; pulse_gate_o forced 0.
- Drop channel_enable_i with length 254 → length 0 next clk. A $4003 write while disabled → length stays 0. Set halt=1 and apply half_frames → no decrement.
- Assert rst_n_i low asynchronously mid-waveform, between clock edges → all outputs 0 immediately. muting_is_inactive_i=0 alone → pulse_gate_o=0 one clk later.
